// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 constants, divider state encoding and field helpers.
package fpu_pkg;
    localparam logic [31:0]       QNAN      = 32'h7fc00000;
    localparam logic signed [9:0] BIAS      = 10'sd127;
    localparam logic signed [9:0] EXP_MAX   = 10'sd255;
    localparam logic [4:0]        DIV_ITERS = 5'd26;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fdiv_state_t;

    function automatic logic f_sign(input logic [31:0] a);
        return a[31];
    endfunction

    function automatic logic [7:0] f_exp(input logic [31:0] a);
        return a[30:23];
    endfunction

    function automatic logic [22:0] f_mant(input logic [31:0] a);
        return a[22:0];
    endfunction

    // Denormals count as zero throughout the FPU.
    function automatic logic is_zero(input logic [31:0] a);
        return f_exp(a) == 8'd0;
    endfunction

    function automatic logic is_inf(input logic [31:0] a);
        return f_exp(a) == 8'hff && f_mant(a) == 23'd0;
    endfunction

    function automatic logic is_nan(input logic [31:0] a);
        return f_exp(a) == 8'hff && f_mant(a) != 23'd0;
    endfunction
endpackage

// File: rtl/fdiv_round.sv
// fdiv_round: normalise a 26-bit quotient, round to nearest even and pack to binary32.
module fdiv_round
    import fpu_pkg::*;
(
    input  logic              s,
    input  logic signed [9:0] e,
    input  logic [25:0]       q,
    input  logic              r_nonzero,
    output logic [31:0]       res
);
    logic [23:0]       mant;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [24:0]       sum;
    logic [22:0]       frac;
    logic signed [9:0] en;
    logic signed [9:0] ef;

    always_comb begin
        mant   = q[25] ? q[25:2] : q[24:1];
        guard  = q[25] ? q[1] : q[0];
        sticky = q[25] ? (q[0] | r_nonzero) : r_nonzero;
        en     = q[25] ? e : e - 10'sd1;
        inc    = guard & (sticky | mant[0]);
        sum    = {1'b0, mant} + {24'd0, inc};
        frac   = sum[24] ? sum[23:1] : sum[22:0];
        ef     = sum[24] ? en + 10'sd1 : en;
        res    = (ef >= EXP_MAX) ? {s, 8'hff, 23'd0} :
                 (ef <= 10'sd0)  ? {s, 31'd0} : {s, ef[7:0], frac};
    end
endmodule

// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential binary32 divider, restoring radix-2 loop with valid/ready handshakes.
module fdiv_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    fdiv_state_t       state, state_nxt;
    logic [4:0]        cnt;
    logic [23:0]       my;
    logic [24:0]       r;
    logic [25:0]       q;
    logic signed [9:0] e;
    logic              s;
    logic              sx;
    logic              special;
    logic              ge;
    logic [31:0]       special_res;
    logic [31:0]       round_res;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        sx          = f_sign(x) ^ f_sign(y);
        special     = is_zero(x) | is_zero(y) | f_exp(x) == 8'hff | f_exp(y) == 8'hff;
        special_res = (is_nan(x) | is_nan(y) | (is_zero(x) & is_zero(y)) | (is_inf(x) & is_inf(y))) ? QNAN :
                      (is_inf(x) | is_zero(y)) ? {sx, 8'hff, 23'd0} : {sx, 31'd0};
        ge          = r >= {1'b0, my};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? (special ? DONE : DIV) : IDLE;
            DIV:     state_nxt = (cnt == DIV_ITERS - 5'd1) ? ROUND : DIV;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            my     <= 24'd0;
            r      <= 25'd0;
            q      <= 26'd0;
            e      <= 10'sd0;
            s      <= 1'b0;
            result <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                s   <= sx;
                e   <= $signed({2'b00, f_exp(x)}) - $signed({2'b00, f_exp(y)}) + BIAS;
                my  <= {1'b1, f_mant(y)};
                r   <= {2'b01, f_mant(x)};
                q   <= 26'd0;
                cnt <= 5'd0;
                if (special)
                    result <= special_res;
            end
            // One restoring step per cycle; the remainder stays below 2*my so 25 bits suffice.
            if (state == DIV) begin
                q   <= {q[24:0], ge};
                r   <= (ge ? r - {1'b0, my} : r) << 1;
                cnt <= cnt + 5'd1;
            end
            if (state == ROUND)
                result <= round_res;
        end
    end

    fdiv_round u_round (
        .s        (s),
        .e        (e),
        .q        (q),
        .r_nonzero(r != 25'd0),
        .res      (round_res)
    );
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed and randomized checks of fdiv_seq against an exact-division model.
module tb_fdiv_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] result;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fdiv_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact quotient by integer division, then round-to-nearest-even on the remainder.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        int          ea = int'(a[30:23]);
        int          eb = int'(b[30:23]);
        int          e;
        logic        s = a[31] ^ b[31];
        logic        az = ea == 0;
        logic        bz = eb == 0;
        logic        ai = ea == 255 && a[22:0] == 0;
        logic        bi = eb == 255 && b[22:0] == 0;
        logic        an = ea == 255 && a[22:0] != 0;
        logic        bn = eb == 255 && b[22:0] != 0;
        logic [63:0] ma = {40'd0, 1'b1, a[22:0]};
        logic [63:0] mb = {40'd0, 1'b1, b[22:0]};
        logic [63:0] num;
        logic [63:0] qq;
        logic [63:0] rem;
        if (an || bn || (az && bz) || (ai && bi)) return 32'h7fc00000;
        if (ai || bz) return {s, 8'hff, 23'd0};
        if (az || bi) return {s, 31'd0};
        e = ea - eb + 127;
        if (ma < mb) begin
            num = ma << 24;
            e = e - 1;
        end else begin
            num = ma << 23;
        end
        qq  = num / mb;
        rem = num % mb;
        if (2 * rem > mb || (2 * rem == mb && qq[0])) qq = qq + 1;
        if (qq == (64'd1 << 24)) begin
            qq = qq >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], qq[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        logic [31:0] sp [6];
        sp = '{32'h00000000, 32'h80000000, 32'h7f800000, 32'hff800000, 32'h7fc00001, 32'h00012345};
        if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 5)];
        v = $urandom;
        v[30:23] = 8'($urandom_range(1, 254));
        return v;
    endfunction

    // Drives one full transaction; lat = edges from acceptance until out_valid is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res, output int lat);
        int n = 0;
        x = a;
        y = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = result;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = 32'd0;
        y = 32'd0;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int          lat;
        int          n = 0;
        logic        busy = 1'b0;
        x = 32'h40c00000;
        y = 32'h40000000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin
            busy = busy | in_ready;
            tick();
            n++;
        end
        checks++;
        if (n + 1 != 28) begin errors++; $display("FAIL div_latency got %0d want 28", n + 1); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL div_in_ready_low got %b want 0", busy); end
        checks++;
        if (result !== 32'h40400000) begin errors++; $display("FAIL six_by_two got %h want 40400000", result); end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_transfer got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
        run_op(32'h3f800000, 32'h40400000, res, lat);
        checks++;
        if (res !== 32'h3eaaaaab) begin errors++; $display("FAIL one_third got %h want 3eaaaaab", res); end
        run_op(32'h3f800000, 32'h3f800000, res, lat);
        checks++;
        if (res !== 32'h3f800000) begin errors++; $display("FAIL one_by_one got %h want 3f800000", res); end
    endtask

    task automatic test_special();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [31:0] te [3];
        ta = '{32'h3f800000, 32'h00000000, 32'hbf800000};
        tb = '{32'h00000000, 32'h00000000, 32'h7f800000};
        te = '{32'h7f800000, 32'h7fc00000, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            x = ta[i];
            y = tb[i];
            in_valid = 1'b1;
            out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL special%0d_busy got %b want 0", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL special%0d_valid got %b want 1", i, out_valid); end
            checks++;
            if (result !== te[i]) begin errors++; $display("FAIL special%0d_result got %h want %h", i, result, te[i]); end
            out_ready = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL special%0d_drain got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_range();
        logic [31:0] res;
        int          lat;
        run_op(32'h7f000000, 32'h3e800000, res, lat);
        checks++;
        if (res !== 32'h7f800000) begin errors++; $display("FAIL overflow got %h want 7f800000", res); end
        run_op(32'h00800000, 32'h4b000000, res, lat);
        checks++;
        if (res !== 32'h00000000) begin errors++; $display("FAIL underflow got %h want 00000000", res); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] exp_res;
        int          lat;
        for (int i = 0; i < 150; i++) begin
            a = rand_op();
            b = rand_op();
            exp_res = model(a, b);
            run_op(a, b, res, lat);
            checks++;
            if (res !== exp_res) begin errors++; $display("FAIL random%0d %h/%h got %h want %h", i, a, b, res, exp_res); end
            if (a[30:23] != 8'd0 && a[30:23] != 8'hff && b[30:23] != 8'd0 && b[30:23] != 8'hff) begin
                checks++;
                if (lat != 27) begin errors++; $display("FAIL random%0d_latency got %0d want 28", i, lat + 1); end
            end
        end
    endtask

    task automatic test_backpressure();
        int   n = 0;
        logic stable = 1'b1;
        logic blocked = 1'b1;
        x = 32'h3f800000;
        y = 32'h40400000;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", out_valid); end
        x = 32'h40c00000;
        y = 32'h40000000;
        in_valid = 1'b1;
        repeat (10) begin
            tick();
            if (result !== 32'h3eaaaaab || out_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0) blocked = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", stable); end
        checks++;
        if (blocked !== 1'b1) begin errors++; $display("FAIL bp_in_ready_low got %b want 1", blocked); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ignored_input got rdy=%b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        logic        quiet = 1'b1;
        x = 32'h40c00000;
        y = 32'h40000000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL midreset_result got %h want 00000000", result); end
        repeat (30) begin
            tick();
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin errors++; $display("FAIL midreset_no_output got %b want 1", quiet); end
        run_op(32'h40c00000, 32'h40000000, res, lat);
        checks++;
        if (res !== 32'h40400000) begin errors++; $display("FAIL midreset_rerun got %h want 40400000", res); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        x = 32'h3f800000;
        y = 32'h3f800000;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        x = 32'h40c00000;
        y = 32'h40000000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_overlap got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n + 1 != 28) begin errors++; $display("FAIL b2b_latency got %0d want 28", n + 1); end
        checks++;
        if (result !== 32'h40400000) begin errors++; $display("FAIL b2b_result got %h want 40400000", result); end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
